// File: rtl/nios_lcd_cmd_sequencer.sv
// nios_lcd_cmd_sequencer: turns PIO command words into timed HD44780 write cycles with busy/overflow status.
// Optional LCD_SEQ_PWR_CTRL_EN: lcd_on/lcd_blon follow cmd_in[13]/[14] instead of being tied high.
module nios_lcd_cmd_sequencer #(
  parameter int SETUP_CYC     = 4,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 4,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int CNT_W         = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [16:0] cmd_in,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy,
  output logic        overflow
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [8:0]         pend_word;
  logic               go_q, pending, req, start, long_cmd;
  assign req      = cmd_in[16] ^ go_q;
  // a buffered request launches straight out of WAIT, or from IDLE if caught in the last WAIT cycle
  assign start    = (state == IDLE && (pending || req)) || (state == WAIT && cnt == '0 && pending);
  assign long_cmd = !lcd_rs && lcd_data[7:2] == 6'd0 && lcd_data[1:0] != 2'd0;
  assign lcd_en   = state == PULSE;
  assign lcd_rw   = 1'b0;
  assign busy     = state != IDLE || pending;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (start) begin
      state_n = SETUP;
      cnt_n   = CNT_W'(SETUP_CYC - 1);
    end else if (state != IDLE && cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      case (state)
        SETUP: begin state_n = PULSE; cnt_n = CNT_W'(PULSE_CYC - 1); end
        PULSE: begin state_n = HOLD;  cnt_n = CNT_W'(HOLD_CYC - 1); end
        HOLD:  begin state_n = WAIT;  cnt_n = long_cmd ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1); end
        WAIT:  state_n = IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      go_q      <= 1'b0;
      pending   <= 1'b0;
      pend_word <= '0;
      overflow  <= 1'b0;
      lcd_data  <= '0;
      lcd_rs    <= 1'b0;
    end else begin
      go_q  <= cmd_in[16];
      state <= state_n;
      cnt   <= cnt_n;
      if (start) {lcd_rs, lcd_data} <= pending ? pend_word : cmd_in[8:0];
      if (req && pending) overflow <= 1'b1;
      else if (cmd_in[15]) overflow <= 1'b0;
      if (req && !pending && state != IDLE) begin
        pending   <= 1'b1;
        pend_word <= cmd_in[8:0];
      end else if (start && pending) begin
        pending <= 1'b0;
      end
    end
  end
`ifdef LCD_SEQ_PWR_CTRL_EN
  logic unused_bits;
  assign unused_bits = &{1'b0, cmd_in[12:9]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_on   <= 1'b0;
      lcd_blon <= 1'b0;
    end else begin
      lcd_on   <= cmd_in[13];
      lcd_blon <= cmd_in[14];
    end
  end
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, cmd_in[14:9]};
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;
`endif
endmodule

// File: tb/tb_nios_lcd_cmd_sequencer.sv
// tb_nios_lcd_cmd_sequencer: randomized bench against a transaction-timeline reference model.
module tb_nios_lcd_cmd_sequencer;
  localparam int S = 4, P = 12, H = 4, W = 60, L = 300;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] cmd_in;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, overflow;
  int          total = 0, bad = 0;
  bit          m_go, m_active, m_pend, m_ovf, m_busy, m_en, m_on, m_blon;
  logic [8:0]  m_cur, m_pbuf;
  int          m_el;

  nios_lcd_cmd_sequencer #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W),
                           .LONG_WAIT_CYC(L), .CNT_W(17)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_in(cmd_in), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .lcd_blon(lcd_blon), .busy(busy),
    .overflow(overflow));

  always #5 clk = ~clk;

  function automatic int dur(input logic [8:0] w);
    return S + P + H + ((!w[8] && w[7:2] == 6'd0 && w[7:0] != 8'd0) ? L : W);
  endfunction

  task automatic model_reset();
    m_go = 0; m_active = 0; m_pend = 0; m_ovf = 0; m_busy = 0; m_en = 0;
    m_cur = '0; m_pbuf = '0; m_el = 0;
`ifdef LCD_SEQ_PWR_CTRL_EN
    m_on = 0; m_blon = 0;
`else
    m_on = 1; m_blon = 1;
`endif
  endtask

  // one clock of the software-visible behaviour: a transaction occupies dur(word) clocks from launch
  task automatic model_step();
    bit req, fin, st, old_pend;
    req = cmd_in[16] ^ m_go;
    m_go = cmd_in[16];
    fin = m_active && m_el == dur(m_cur) - 1;
    old_pend = m_pend;
    st = (!m_active && (m_pend || req)) || (fin && m_pend);
    if (req && old_pend) m_ovf = 1;
    else if (cmd_in[15]) m_ovf = 0;
    if (req && !old_pend && m_active) begin
      m_pend = 1;
      m_pbuf = cmd_in[8:0];
    end else if (st && old_pend) m_pend = 0;
    if (st) begin
      m_cur = old_pend ? m_pbuf : cmd_in[8:0];
      m_active = 1;
      m_el = 0;
    end else if (fin) m_active = 0;
    else if (m_active) m_el++;
    m_busy = m_active || m_pend;
    m_en = m_active && m_el >= S && m_el < S + P;
`ifdef LCD_SEQ_PWR_CTRL_EN
    m_on = cmd_in[13]; m_blon = cmd_in[14];
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_en, busy, overflow} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {lcd_data, lcd_rs, lcd_rw, lcd_en, busy, overflow});
    end
    total++;
    if ({lcd_on, lcd_blon} !== {m_on, m_blon}) begin
      bad++;
      $display("FAIL reset_power got=%b want=%b", {lcd_on, lcd_blon}, {m_on, m_blon});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_power();
`ifdef LCD_SEQ_PWR_CTRL_EN
    cmd_in[14:13] = 2'b11;
    tick();
    total++;
    if ({lcd_blon, lcd_on} !== 2'b11) begin
      bad++;
      $display("FAIL power_on got=%b want=11", {lcd_blon, lcd_on});
    end
    cmd_in[14:13] = 2'b01;
    tick();
    total++;
    if ({lcd_blon, lcd_on} !== 2'b01) begin
      bad++;
      $display("FAIL power_mix got=%b want=01", {lcd_blon, lcd_on});
    end
`else
    cmd_in[14:13] = 2'b00;
    tick();
    total++;
    if ({lcd_blon, lcd_on} !== 2'b11) begin
      bad++;
      $display("FAIL power_tied got=%b want=11", {lcd_blon, lcd_on});
    end
`endif
    cmd_in[14:13] = 2'b00;
    tick();
  endtask

  task automatic test_single_txn(input string name, input logic [8:0] word, input int want_busy);
    int first_en = -1, en_n = 0, busy_n = 0;
    cmd_in[8:0] = word;
    cmd_in[16] = ~cmd_in[16];
    for (int k = 1; k < S + P + H + L + 20; k++) begin
      if (k == 3) cmd_in[8:0] = 9'($urandom);
      tick();
      total++;
      if ({busy, lcd_en, lcd_rs, lcd_data, overflow} !== {m_busy, m_en, m_cur, m_ovf}) begin
        bad++;
        $display("FAIL %s_cycle%0d got=%h want=%h", name, k,
                 {busy, lcd_en, lcd_rs, lcd_data, overflow}, {m_busy, m_en, m_cur, m_ovf});
      end
      if (busy) busy_n++;
      if (lcd_en) begin
        en_n++;
        if (first_en < 0) first_en = k;
      end
      if (!busy) break;
    end
    total++;
    if (en_n != P) begin
      bad++;
      $display("FAIL %s_en_width got=%0d want=%0d", name, en_n, P);
    end
    total++;
    if (first_en != 1 + S) begin
      bad++;
      $display("FAIL %s_en_start got=%0d want=%0d", name, first_en, 1 + S);
    end
    total++;
    if (busy_n != want_busy) begin
      bad++;
      $display("FAIL %s_busy_len got=%0d want=%0d", name, busy_n, want_busy);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0;
    bit saw_ovf = 0;
    cmd_in[8:0] = 9'h080;
    cmd_in[16] = ~cmd_in[16];
    for (int k = 1; k < 4 * (S + P + H + L); k++) begin
      if (m_active && m_el == S + P + H + 5 && !m_pend && !saw_ovf) begin
        cmd_in[8:0] = 9'h001;
        cmd_in[16] = ~cmd_in[16];
      end else if (m_pend && !saw_ovf) begin
        cmd_in[8:0] = 9'h1AA;
        cmd_in[16] = ~cmd_in[16];
        saw_ovf = 1;
      end
      tick();
      total++;
      if ({busy, lcd_en, lcd_rs, lcd_data, overflow} !== {m_busy, m_en, m_cur, m_ovf}) begin
        bad++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", k,
                 {busy, lcd_en, lcd_rs, lcd_data, overflow}, {m_busy, m_en, m_cur, m_ovf});
      end
      if (saw_ovf && k < S + P + H + 10) begin
        total++;
        if (overflow !== 1'b1) begin
          bad++;
          $display("FAIL b2b_overflow_set got=%b want=1", overflow);
        end
      end
      if (busy) busy_n++;
      if (!busy) break;
    end
    total++;
    if (busy_n != 2 * (S + P + H) + W + L) begin
      bad++;
      $display("FAIL b2b_busy_len got=%0d want=%0d", busy_n, 2 * (S + P + H) + W + L);
    end
    cmd_in[15] = 1'b1;
    tick();
    cmd_in[15] = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_overflow_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_reset_abort();
    cmd_in[8:0] = 9'h038;
    cmd_in[16] = ~cmd_in[16];
    for (int k = 0; k < S + 4 && !lcd_en; k++) tick();
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({lcd_en, busy, lcd_rs, lcd_data} !== 11'd0) begin
      bad++;
      $display("FAIL abort_async got=%h want=0", {lcd_en, busy, lcd_rs, lcd_data});
    end
    cmd_in = '0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    test_single_txn("after_reset", 9'h0C0, S + P + H + W);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2500; k++) begin
      cmd_in[12:0] = 13'($urandom);
      if ($urandom_range(0, 3) == 0) cmd_in[8:0] = 9'($urandom_range(0, 3));
      cmd_in[15] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) cmd_in[16] = ~cmd_in[16];
      tick();
      total++;
      if ({busy, lcd_en, lcd_rs, lcd_data, overflow, lcd_rw, lcd_on, lcd_blon} !==
          {m_busy, m_en, m_cur, m_ovf, 1'b0, m_on, m_blon}) begin
        bad++;
        $display("FAIL random_cycle%0d got=%h want=%h", k,
                 {busy, lcd_en, lcd_rs, lcd_data, overflow, lcd_rw, lcd_on, lcd_blon},
                 {m_busy, m_en, m_cur, m_ovf, 1'b0, m_on, m_blon});
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_power();
    test_single_txn("cmd", 9'h038, S + P + H + W);
    test_single_txn("data", 9'h141, S + P + H + W);
    test_single_txn("clear", 9'h001, S + P + H + L);
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
